axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI read channel (AR + R) between two read requesters: requester 0 is the instruction cache behind the fetcher, requester 1 is the data cache.
- Grants one burst at a time and holds ownership from the AR handshake until the R beat carrying rlast.
- Uses round-robin priority when both requesters assert arvalid together.
- Checks burst length against rlast and flags mismatches.

Parameters:
- ADDR_WIDTH, 64, width of araddr on all ports.
- DATA_WIDTH, 64, width of rdata on all ports.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rq0_arvalid / rq1_arvalid  input  1  requester AR valid
- rq0_araddr / rq1_araddr  input  ADDR_WIDTH  requester read address
- rq0_arlen / rq1_arlen  input  8  burst length minus one
- rq0_arsize / rq1_arsize  input  3  beat size
- rq0_arburst / rq1_arburst  input  2  burst type
- rq0_arready / rq1_arready  output  1  AR accepted for that requester
- rq0_rvalid / rq1_rvalid  output  1  routed R valid
- rq0_rdata / rq1_rdata  output  DATA_WIDTH  routed R data
- rq0_rlast / rq1_rlast  output  1  routed R last
- rq0_rready / rq1_rready  input  1  requester R ready
- m_axi_arvalid  output  1  AR valid to memory
- m_axi_araddr  output  ADDR_WIDTH  AR address to memory
- m_axi_arlen  output  8  AR length
- m_axi_arsize  output  3  AR size
- m_axi_arburst  output  2  AR burst type
- m_axi_arready  input  1  memory AR ready
- m_axi_rvalid  input  1  memory R valid
- m_axi_rlast  input  1  memory R last
- m_axi_rdata  input  DATA_WIDTH  memory R data
- m_axi_rready  output  1  R ready to memory
- grant  output  2  one-hot current owner; 00 when idle
- busy  output  1  high in ADDR or DATA
- beat_error  output  1  sticky burst/rlast mismatch flag

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state = IDLE, grant = 00, busy = 0, beat_error = 0, last_grant = 1.
  - All arready, rvalid, rlast and m_axi_arvalid/m_axi_rready outputs are 0; all address/data outputs are 0.
  - last_grant = 1 means requester 0 wins the first tie.
- States: IDLE, ADDR, DATA.
- IDLE:
  - All handshake outputs are 0.
  - If exactly one rqN_arvalid is high, register owner = N and go to ADDR.
  - If both are high, owner = the requester that is not last_grant.
  - The arbitration decision is registered: a request seen in cycle N gives m_axi_arvalid high in cycle N+1.
- ADDR:
  - m_axi_ar* fields are driven combinationally from the owner's inputs; m_axi_arvalid = owner arvalid.
  - Owner rqN_arready = m_axi_arready. The non-owner's arready is 0.
  - On the handshake (m_axi_arvalid && m_axi_arready): load beat_cnt = m_axi_arlen and go to DATA.
  - No abandonment: the block stays in ADDR until the handshake. A requester must hold AR stable per AXI.
- DATA:
  - Owner rqN_rvalid/rdata/rlast = m_axi_rvalid/rdata/rlast, and m_axi_rready = owner rqN_rready.
  - The non-owner sees rvalid = 0, rlast = 0, rdata = 0.
  - m_axi_arvalid = 0 and both arready are 0.
  - On each beat handshake (m_axi_rvalid && m_axi_rready):
    - If m_axi_rlast is high and beat_cnt != 0, set beat_error.
    - If m_axi_rlast is low and beat_cnt == 0, set beat_error and keep beat_cnt at 0 (no underflow).
    - Otherwise decrement beat_cnt.
  - On the rlast beat: last_grant = owner, go to IDLE.
  - Only rlast ends a burst; an over-long burst stays in DATA until rlast.
- Minimum of one IDLE cycle between consecutive bursts. Back-to-back requests from the same requester are allowed but lose ties to the other requester.
- An arvalid arriving during ADDR/DATA is held off (arready = 0) and arbitrated in the next IDLE.
- beat_cnt is 8 bits; arlen = 0 means a single beat carrying rlast.
- beat_error clears only on reset.
- No combinational path from m_axi_rvalid to any AR output.

Test Plan:
- Single burst: rq0 requests araddr=0x1000, arlen=7. Required: m_axi_arvalid one cycle later; grant=01; 8 beats 0xA0..0xA7 delivered only to rq0; rq0_rlast on beat 8; IDLE next cycle; beat_error=0.
- Tie: rq0 and rq1 assert in the same cycle from reset. Required: rq0 granted first. With both re-requesting, rq1 is granted next, then rq0 (strict alternation across 4 bursts).
- Backpressure: rq1 burst with arlen=3 and rq1_rready toggling 1,0,0,1. Required: m_axi_rready mirrors it, each beat is transferred exactly once, and rq0_rvalid stays 0 throughout.
- Hold-off: rq1 asserts arvalid during rq0's DATA phase. Required: rq1_arready=0 until rq0's rlast; rq1 granted in the cycle after the following IDLE; m_axi_araddr = rq1 address.
- Protocol error: arlen=3 but rlast arrives on beat 2. Required: beat_error=1 (sticky), state returns to IDLE, and the next burst proceeds normally.
- Reset mid-DATA: assert reset at beat 3 of an 8-beat burst. Required: in the same cycle all handshake outputs are 0, grant=00, busy=0; after release, requester 0 wins the first tie.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// One AXI read channel (AR + R) bundle, shared by requester and memory sides.
interface axi_read_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rready;

    // The side that issues read requests.
    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rlast
    );

    // The side that answers read requests.
    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: icache (rq0) and dcache (rq1) share one
// AR/R channel, one burst at a time, round-robin on ties, with burst-length
// checking against rlast.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    axi_read_arbiter_if.slave   rq0,
    axi_read_arbiter_if.slave   rq1,
    axi_read_arbiter_if.master  m_axi,
    output logic [1:0]          grant,
    output logic                busy,
    output logic                beat_error
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       beat_error_q, beat_error_d;

    logic                  sel_arvalid;
    logic [ADDR_WIDTH-1:0] sel_araddr;
    logic [7:0]            sel_arlen;
    logic [2:0]            sel_arsize;
    logic [1:0]            sel_arburst;
    logic                  sel_rready;

    // Pick the current owner's request and R-ready signals.
    always_comb begin
        sel_arvalid = owner_q ? rq1.arvalid : rq0.arvalid;
        sel_araddr  = owner_q ? rq1.araddr  : rq0.araddr;
        sel_arlen   = owner_q ? rq1.arlen   : rq0.arlen;
        sel_arsize  = owner_q ? rq1.arsize  : rq0.arsize;
        sel_arburst = owner_q ? rq1.arburst : rq0.arburst;
        sel_rready  = owner_q ? rq1.rready  : rq0.rready;
    end

    // Route AR toward memory in ADDR and R back to the owner in DATA; everything else idles at zero.
    always_comb begin
        m_axi.arvalid = 1'b0;
        m_axi.araddr  = {ADDR_WIDTH{1'b0}};
        m_axi.arlen   = 8'd0;
        m_axi.arsize  = 3'd0;
        m_axi.arburst = 2'd0;
        m_axi.rready  = 1'b0;
        rq0.arready   = 1'b0;
        rq1.arready   = 1'b0;
        rq0.rvalid    = 1'b0;
        rq1.rvalid    = 1'b0;
        rq0.rdata     = {DATA_WIDTH{1'b0}};
        rq1.rdata     = {DATA_WIDTH{1'b0}};
        rq0.rlast     = 1'b0;
        rq1.rlast     = 1'b0;
        case (state_q)
            ADDR: begin
                m_axi.arvalid = sel_arvalid;
                m_axi.araddr  = sel_araddr;
                m_axi.arlen   = sel_arlen;
                m_axi.arsize  = sel_arsize;
                m_axi.arburst = sel_arburst;
                if (owner_q) rq1.arready = m_axi.arready;
                else         rq0.arready = m_axi.arready;
            end
            DATA: begin
                m_axi.rready = sel_rready;
                if (owner_q) begin
                    rq1.rvalid = m_axi.rvalid;
                    rq1.rdata  = m_axi.rdata;
                    rq1.rlast  = m_axi.rlast;
                end else begin
                    rq0.rvalid = m_axi.rvalid;
                    rq0.rdata  = m_axi.rdata;
                    rq0.rlast  = m_axi.rlast;
                end
            end
            default: ;
        endcase
    end

    // Arbitration, burst ownership and beat counting; a short or long burst only sets the sticky flag.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        beat_error_d = beat_error_q;
        case (state_q)
            IDLE: begin
                if (rq0.arvalid && rq1.arvalid) begin
                    owner_d = ~last_grant_q;
                    state_d = ADDR;
                end else if (rq0.arvalid) begin
                    owner_d = 1'b0;
                    state_d = ADDR;
                end else if (rq1.arvalid) begin
                    owner_d = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (sel_arvalid && m_axi.arready) begin
                    beat_cnt_d = sel_arlen;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (m_axi.rvalid && sel_rready) begin
                    if (m_axi.rlast) begin
                        if (beat_cnt_q != 8'd0) beat_error_d = 1'b1;
                        last_grant_d = owner_q;
                        state_d      = IDLE;
                    end else if (beat_cnt_q == 8'd0) begin
                        beat_error_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset makes requester 0 the winner of the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            beat_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_error_q <= beat_error_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign grant      = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign beat_error = beat_error_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: the bench plays both caches and memory,
// and a scoreboard matches every beat delivered to a requester.
module tb_axi_read_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       beat_error;

    axi_read_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) rq0_if ();
    axi_read_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) rq1_if ();
    axi_read_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m_if ();

    axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .rq0(rq0_if), .rq1(rq1_if), .m_axi(m_if),
        .grant(grant), .busy(busy), .beat_error(beat_error)
    );

    typedef struct packed { logic id; logic [63:0] data; logic last; } beat_t;
    beat_t exp_q[$];
    beat_t sb_b;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Scoreboard: every beat accepted by a requester must match the oldest expected beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (rq0_if.rvalid === 1'b1 && rq0_if.rready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL sb_rq0 unexpected beat got data=%h", rq0_if.rdata);
                else begin
                    sb_b = exp_q.pop_front();
                    if (sb_b.id !== 1'b0 || rq0_if.rdata !== sb_b.data || rq0_if.rlast !== sb_b.last)
                        $display("[TB] FAIL sb_rq0 got id=0 data=%h last=%b want id=%0d data=%h last=%b", rq0_if.rdata, rq0_if.rlast, sb_b.id, sb_b.data, sb_b.last);
                    else n_pass++;
                end
            end
            if (rq1_if.rvalid === 1'b1 && rq1_if.rready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL sb_rq1 unexpected beat got data=%h", rq1_if.rdata);
                else begin
                    sb_b = exp_q.pop_front();
                    if (sb_b.id !== 1'b1 || rq1_if.rdata !== sb_b.data || rq1_if.rlast !== sb_b.last)
                        $display("[TB] FAIL sb_rq1 got id=1 data=%h last=%b want id=%0d data=%h last=%b", rq1_if.rdata, rq1_if.rlast, sb_b.id, sb_b.data, sb_b.last);
                    else n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input bit who, input logic [63:0] addr, input logic [7:0] len, input logic v);
        if (who == 1'b0) begin
            rq0_if.arvalid = v; rq0_if.araddr = addr; rq0_if.arlen = len; rq0_if.arsize = 3'd3; rq0_if.arburst = 2'b01;
        end else begin
            rq1_if.arvalid = v; rq1_if.araddr = addr; rq1_if.arlen = len; rq1_if.arsize = 3'd3; rq1_if.arburst = 2'b01;
        end
    endtask

    // Leaves the bench at a falling edge with m_axi arvalid high, or reports a timeout via ok.
    task automatic wait_arvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_if.arvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept_ar(input bit who, output logic seen_arready);
        m_if.arready = 1'b1;
        #1;
        seen_arready = who ? rq1_if.arready : rq0_if.arready;
        @(posedge clk);
        #1;
        m_if.arready = 1'b0;
        if (who) rq1_if.arvalid = 1'b0;
        else     rq0_if.arvalid = 1'b0;
    endtask

    // Memory model: one beat per cycle, owner always ready; expected beats go to the scoreboard.
    task automatic serve_beats(input bit who, input int nbeats, input logic [63:0] base, input int last_at);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            m_if.rvalid = 1'b1;
            m_if.rdata  = base + 64'(i);
            m_if.rlast  = (i == last_at);
            b.id = who; b.data = base + 64'(i); b.last = (i == last_at);
            exp_q.push_back(b);
            tick();
        end
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
        m_if.rdata  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_if.rvalid = 1'b1;
        #1;
        n_checks++; if (grant !== 2'b00) $display("[TB] FAIL reset_grant got=%b want=00", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (beat_error !== 1'b0) $display("[TB] FAIL reset_beat_error got=%b want=0", beat_error); else n_pass++;
        n_checks++; if (m_if.arvalid !== 1'b0 || m_if.rready !== 1'b0) $display("[TB] FAIL reset_m_hs got arvalid=%b rready=%b want 0 0", m_if.arvalid, m_if.rready); else n_pass++;
        n_checks++; if (m_if.araddr !== 64'd0) $display("[TB] FAIL reset_araddr got=%h want=0", m_if.araddr); else n_pass++;
        n_checks++; if (rq0_if.rvalid !== 1'b0 || rq0_if.arready !== 1'b0) $display("[TB] FAIL reset_rq0 got rvalid=%b arready=%b want 0 0", rq0_if.rvalid, rq0_if.arready); else n_pass++;
        m_if.rvalid = 1'b0;
        do_reset();
    endtask

    task automatic test_single_burst();
        logic seen;
        set_req(0, 64'h1000, 8'd7, 1'b1);
        @(negedge clk);
        n_checks++; if (m_if.arvalid !== 1'b0) $display("[TB] FAIL single_arvalid_early got=%b want=0", m_if.arvalid); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (m_if.arvalid !== 1'b1) $display("[TB] FAIL single_arvalid got=%b want=1", m_if.arvalid); else n_pass++;
        n_checks++; if (grant !== 2'b01) $display("[TB] FAIL single_grant got=%b want=01", grant); else n_pass++;
        n_checks++; if (m_if.araddr !== 64'h1000 || m_if.arlen !== 8'd7) $display("[TB] FAIL single_ar got addr=%h len=%0d want 1000 7", m_if.araddr, m_if.arlen); else n_pass++;
        n_checks++; if (rq1_if.arready !== 1'b0) $display("[TB] FAIL single_rq1_arready got=%b want=0", rq1_if.arready); else n_pass++;
        accept_ar(0, seen);
        n_checks++; if (seen !== 1'b1) $display("[TB] FAIL single_rq0_arready got=%b want=1", seen); else n_pass++;
        serve_beats(0, 8, 64'hA0, 7);
        @(negedge clk);
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0) $display("[TB] FAIL single_idle got grant=%b busy=%b want 00 0", grant, busy); else n_pass++;
        n_checks++; if (beat_error !== 1'b0) $display("[TB] FAIL single_beat_error got=%b want=0", beat_error); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL single_drain got=%0d pending want=0", exp_q.size()); else n_pass++;
        tick();
    endtask

    task automatic test_tie();
        bit ok;
        logic seen;
        bit who;
        logic [63:0] addr;
        do_reset();
        set_req(0, 64'h100, 8'd0, 1'b1);
        set_req(1, 64'h200, 8'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            who  = k[0];
            addr = who ? 64'h200 : 64'h100;
            wait_arvalid(ok);
            n_checks++; if (!ok) $display("[TB] FAIL tie_timeout got=no arvalid want=arvalid burst=%0d", k); else n_pass++;
            n_checks++; if (grant !== (who ? 2'b10 : 2'b01)) $display("[TB] FAIL tie_grant burst=%0d got=%b want=%b", k, grant, (who ? 2'b10 : 2'b01)); else n_pass++;
            n_checks++; if (m_if.araddr !== addr) $display("[TB] FAIL tie_araddr burst=%0d got=%h want=%h", k, m_if.araddr, addr); else n_pass++;
            accept_ar(who, seen);
            serve_beats(who, 1, 64'hB0 + 64'(k), 0);
            set_req(who, addr, 8'd0, (k < 3));
        end
        set_req(0, 64'h100, 8'd0, 1'b0);
        set_req(1, 64'h200, 8'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL tie_drain got=%0d pending want=0", exp_q.size()); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic seen;
        logic [3:0] pat = 4'b1001;
        logic rdy;
        beat_t b;
        int i = 0;
        int p = 0;
        set_req(1, 64'h3000, 8'd3, 1'b1);
        wait_arvalid(ok);
        n_checks++; if (!ok || grant !== 2'b10) $display("[TB] FAIL bp_grant got ok=%0d grant=%b want 1 10", ok, grant); else n_pass++;
        accept_ar(1, seen);
        while (i < 4 && p < 20) begin
            rdy = pat[p % 4];
            m_if.rvalid = 1'b1;
            m_if.rdata  = 64'hC0 + 64'(i);
            m_if.rlast  = (i == 3);
            rq1_if.rready = rdy;
            if (rdy) begin
                b.id = 1'b1; b.data = 64'hC0 + 64'(i); b.last = (i == 3);
                exp_q.push_back(b);
            end
            @(negedge clk);
            n_checks++; if (m_if.rready !== rdy) $display("[TB] FAIL bp_rready cycle=%0d got=%b want=%b", p, m_if.rready, rdy); else n_pass++;
            n_checks++; if (rq0_if.rvalid !== 1'b0) $display("[TB] FAIL bp_rq0_rvalid cycle=%0d got=%b want=0", p, rq0_if.rvalid); else n_pass++;
            tick();
            if (rdy) i++;
            p++;
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; rq1_if.rready = 1'b1;
        @(negedge clk);
        n_checks++; if (grant !== 2'b00 || exp_q.size() != 0) $display("[TB] FAIL bp_end got grant=%b pending=%0d want 00 0", grant, exp_q.size()); else n_pass++;
        tick();
    endtask

    task automatic test_hold_off();
        bit ok;
        logic seen;
        beat_t b;
        set_req(0, 64'h1000, 8'd3, 1'b1);
        wait_arvalid(ok);
        n_checks++; if (!ok || grant !== 2'b01) $display("[TB] FAIL hold_grant0 got ok=%0d grant=%b want 1 01", ok, grant); else n_pass++;
        accept_ar(0, seen);
        set_req(1, 64'h2000, 8'd1, 1'b1);
        m_if.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_if.rvalid = 1'b1;
            m_if.rdata  = 64'hD0 + 64'(i);
            m_if.rlast  = (i == 3);
            b.id = 1'b0; b.data = 64'hD0 + 64'(i); b.last = (i == 3);
            exp_q.push_back(b);
            @(negedge clk);
            n_checks++; if (rq1_if.arready !== 1'b0 || m_if.arvalid !== 1'b0) $display("[TB] FAIL hold_data beat=%0d got arready=%b arvalid=%b want 0 0", i, rq1_if.arready, m_if.arvalid); else n_pass++;
            tick();
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 2'b00 || m_if.arvalid !== 1'b0 || rq1_if.arready !== 1'b0) $display("[TB] FAIL hold_idle got grant=%b arvalid=%b arready=%b want 00 0 0", grant, m_if.arvalid, rq1_if.arready); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (grant !== 2'b10 || m_if.arvalid !== 1'b1) $display("[TB] FAIL hold_grant1 got grant=%b arvalid=%b want 10 1", grant, m_if.arvalid); else n_pass++;
        n_checks++; if (m_if.araddr !== 64'h2000 || rq1_if.arready !== 1'b1) $display("[TB] FAIL hold_ar1 got addr=%h arready=%b want 2000 1", m_if.araddr, rq1_if.arready); else n_pass++;
        tick();
        m_if.arready = 1'b0;
        rq1_if.arvalid = 1'b0;
        serve_beats(1, 2, 64'hE0, 1);
        @(negedge clk);
        n_checks++; if (grant !== 2'b00 || exp_q.size() != 0) $display("[TB] FAIL hold_end got grant=%b pending=%0d want 00 0", grant, exp_q.size()); else n_pass++;
        tick();
    endtask

    task automatic test_protocol_error();
        bit ok;
        logic seen;
        set_req(0, 64'h4000, 8'd3, 1'b1);
        wait_arvalid(ok);
        n_checks++; if (!ok || beat_error !== 1'b0) $display("[TB] FAIL perr_pre got ok=%0d beat_error=%b want 1 0", ok, beat_error); else n_pass++;
        accept_ar(0, seen);
        serve_beats(0, 2, 64'hF0, 1);
        @(negedge clk);
        n_checks++; if (beat_error !== 1'b1) $display("[TB] FAIL perr_flag got=%b want=1", beat_error); else n_pass++;
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0) $display("[TB] FAIL perr_idle got grant=%b busy=%b want 00 0", grant, busy); else n_pass++;
        tick();
        set_req(1, 64'h5000, 8'd1, 1'b1);
        wait_arvalid(ok);
        n_checks++; if (!ok || grant !== 2'b10) $display("[TB] FAIL perr_next_grant got ok=%0d grant=%b want 1 10", ok, grant); else n_pass++;
        accept_ar(1, seen);
        serve_beats(1, 2, 64'h50, 1);
        @(negedge clk);
        n_checks++; if (beat_error !== 1'b1) $display("[TB] FAIL perr_sticky got=%b want=1", beat_error); else n_pass++;
        n_checks++; if (grant !== 2'b00 || exp_q.size() != 0) $display("[TB] FAIL perr_end got grant=%b pending=%0d want 00 0", grant, exp_q.size()); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_data();
        bit ok;
        logic seen;
        set_req(0, 64'h6000, 8'd7, 1'b1);
        wait_arvalid(ok);
        n_checks++; if (!ok || grant !== 2'b01) $display("[TB] FAIL rst_mid_grant got ok=%0d grant=%b want 1 01", ok, grant); else n_pass++;
        accept_ar(0, seen);
        serve_beats(0, 2, 64'h60, 99);
        m_if.rvalid = 1'b1;
        m_if.rdata  = 64'h62;
        reset = 1'b1;
        #1;
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0) $display("[TB] FAIL rst_mid_state got grant=%b busy=%b want 00 0", grant, busy); else n_pass++;
        n_checks++; if (rq0_if.rvalid !== 1'b0 || m_if.rready !== 1'b0 || m_if.arvalid !== 1'b0) $display("[TB] FAIL rst_mid_hs got rvalid=%b rready=%b arvalid=%b want 0 0 0", rq0_if.rvalid, m_if.rready, m_if.arvalid); else n_pass++;
        n_checks++; if (beat_error !== 1'b0) $display("[TB] FAIL rst_mid_beat_error got=%b want=0", beat_error); else n_pass++;
        m_if.rvalid = 1'b0;
        m_if.rdata  = '0;
        tick();
        reset = 1'b0;
        set_req(0, 64'h7000, 8'd0, 1'b1);
        set_req(1, 64'h8000, 8'd0, 1'b1);
        wait_arvalid(ok);
        n_checks++; if (!ok || grant !== 2'b01 || m_if.araddr !== 64'h7000) $display("[TB] FAIL rst_mid_tie got ok=%0d grant=%b addr=%h want 1 01 7000", ok, grant, m_if.araddr); else n_pass++;
        accept_ar(0, seen);
        serve_beats(0, 1, 64'h70, 0);
        wait_arvalid(ok);
        n_checks++; if (!ok || grant !== 2'b10) $display("[TB] FAIL rst_mid_second got ok=%0d grant=%b want 1 10", ok, grant); else n_pass++;
        accept_ar(1, seen);
        serve_beats(1, 1, 64'h80, 0);
        @(negedge clk);
        n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL rst_mid_drain got=%0d pending want=0", exp_q.size()); else n_pass++;
        tick();
    endtask

    // Global watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        rq0_if.arvalid = 1'b0; rq0_if.araddr = '0; rq0_if.arlen = '0; rq0_if.arsize = '0; rq0_if.arburst = '0; rq0_if.rready = 1'b1;
        rq1_if.arvalid = 1'b0; rq1_if.araddr = '0; rq1_if.arlen = '0; rq1_if.arsize = '0; rq1_if.arburst = '0; rq1_if.rready = 1'b1;
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rlast = 1'b0;
        #2;
        test_reset();
        test_single_burst();
        test_tie();
        test_backpressure();
        test_hold_off();
        test_protocol_error();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
